caliptra_fpga_sync_apb_seq: RTL and testbench

- Hardware APB master sequencer for the FPGA sync wrapper.
- Accepts one host command (addr/wdata/write/user/prot) over a valid/ready interface and drives a complete APB transfer into the gated-clock Caliptra core.
- Phase advance is qualified by the DUT clock enable, so transfers stay correct while the core is single-stepped or breakpointed.
- Returns read data, slave error and timeout status over a valid/ready response interface.

---
 rtl/caliptra_fpga_sync_apb_seq.sv | 148 ++++++++++++++
 tb/tb_caliptra_fpga_sync_apb_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/caliptra_fpga_sync_apb_seq.sv
// APB master sequencer: one host command in, one APB transfer out, one response back.
// Optional transfer statistics ports are enabled by defining CALIPTRA_FPGA_SYNC_APB_STATS_EN.
module caliptra_fpga_sync_apb_seq #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int USER_W = 32,
    parameter int TMO_W  = 16
) (
    input  logic              aclk,
    input  logic              rstn,
    input  logic              clk_en,
    input  logic [TMO_W-1:0]  tmo_cycles,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [USER_W-1:0] cmd_user,
    input  logic [2:0]        cmd_prot,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [2:0]        pprot,
    output logic [USER_W-1:0] pauser,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy
`ifdef CALIPTRA_FPGA_SYNC_APB_STATS_EN
    ,
    output logic [31:0]       stat_txn,
    output logic [15:0]       stat_err,
    output logic [15:0]       stat_tmo
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_cnt_inc;
    logic             tmo_hit;
    logic             access_edge;
    logic             rsp_fire;

    assign cmd_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign access_edge = (state == S_ACCESS) && clk_en;
    assign rsp_fire    = (state == S_RESP) && rsp_ready;
    assign tmo_cnt_inc = tmo_cnt + TMO_W'(1);
    assign tmo_hit     = (tmo_cycles != '0) && (tmo_cnt_inc == tmo_cycles);

    always_comb begin
        // NOTE: default first so every path assigns state_nxt; otherwise a latch is inferred.
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (cmd_valid) state_nxt = S_SETUP;
            S_SETUP:  if (clk_en) state_nxt = S_ACCESS;
            S_ACCESS: if (clk_en && (pready || tmo_hit)) state_nxt = S_RESP;
            S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pprot       <= '0;
            pauser      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state   <= state_nxt;
            psel    <= (state_nxt == S_SETUP) || (state_nxt == S_ACCESS);
            penable <= (state_nxt == S_ACCESS);

            if ((state == S_IDLE) && cmd_valid) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
                pprot  <= cmd_prot;
                pauser <= cmd_user;
            end

            if ((state == S_SETUP) && clk_en) begin
                tmo_cnt <= '0;
            end

            // pready takes priority over a timeout landing on the same enabled edge.
            if (access_edge) begin
                if (pready) begin
                    rsp_valid   <= 1'b1;
                    rsp_rdata   <= pwrite ? '0 : prdata;
                    rsp_slverr  <= pslverr;
                    rsp_timeout <= 1'b0;
                end else if (tmo_hit) begin
                    rsp_valid   <= 1'b1;
                    rsp_rdata   <= '0;
                    rsp_slverr  <= 1'b1;
                    rsp_timeout <= 1'b1;
                end else if (tmo_cnt != '1) begin
                    tmo_cnt <= tmo_cnt_inc;
                end
            end

            if (rsp_fire) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef CALIPTRA_FPGA_SYNC_APB_STATS_EN
    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            stat_txn <= '0;
            stat_err <= '0;
            stat_tmo <= '0;
        end else if (rsp_valid && rsp_ready) begin
            stat_txn <= stat_txn + 32'd1;
            if (rsp_slverr || rsp_timeout) stat_err <= stat_err + 16'd1;
            if (rsp_timeout) stat_tmo <= stat_tmo + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_caliptra_fpga_sync_apb_seq.sv
// Bench for caliptra_fpga_sync_apb_seq: directed vector table, reset abort, and
// randomized transfers predicted from enable/ready streams by a rule-level model.
module tb_caliptra_fpga_sync_apb_seq;

    localparam int MAXC = 1100;
    localparam int NRND = 60;

    logic        aclk = 1'b0;
    logic        rstn;
    logic        clk_en;
    logic [15:0] tmo_cycles;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata, cmd_user;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, pauser, prdata;
    logic [2:0]  pprot;
    logic        pready, pslverr, busy;
`ifdef CALIPTRA_FPGA_SYNC_APB_STATS_EN
    logic [31:0] stat_txn;
    logic [15:0] stat_err, stat_tmo;
`endif

    caliptra_fpga_sync_apb_seq dut (
        .aclk(aclk), .rstn(rstn), .clk_en(clk_en), .tmo_cycles(tmo_cycles),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_user(cmd_user), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pprot(pprot), .pauser(pauser), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .busy(busy)
`ifdef CALIPTRA_FPGA_SYNC_APB_STATS_EN
        , .stat_txn(stat_txn), .stat_err(stat_err), .stat_tmo(stat_tmo)
`endif
    );

    always #5 aclk = ~aclk;

    // One transfer: command fields, stimulus knobs and expected outcome.
    // lat = edges from the accept edge to the edge that raises rsp_valid; s = SETUP->ACCESS edge.
    typedef struct {
        logic        w;
        logic [31:0] addr, wdata, user;
        logic [2:0]  prot;
        int          tmo, hold, period, rdy_from;
        logic [31:0] prd;
        logic        err;
        int          lat, s;
        logic [31:0] rdata;
        logic        slv, to;
    } txn_t;

    bit          en_q[MAXC];
    bit          rdy_q[MAXC];
    bit          err_q[MAXC];
    logic [31:0] rd_q[MAXC];

    int total = 0;
    int bad   = 0;
    int exp_txn = 0, exp_err = 0, exp_tmo = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill_periodic(input txn_t t);
        for (int c = 0; c < MAXC; c++) begin
            en_q[c]  = (c >= 1) && (c % t.period == 0);
            rdy_q[c] = (t.rdy_from >= 0) && (c >= t.rdy_from);
            err_q[c] = t.err;
            rd_q[c]  = t.prd;
        end
    endtask

    // Rule-level prediction: walk the enable stream, first enabled edge ends SETUP,
    // then count enabled access edges until pready or the timeout count is reached.
    function automatic txn_t predict(input txn_t t_in);
        txn_t t = t_in;
        int   k = 0;
        t.s = -1;
        for (int c = 1; c < MAXC; c++) begin
            if (t.s < 0) begin
                if (en_q[c]) t.s = c;
            end else if (en_q[c]) begin
                k++;
                if (rdy_q[c]) begin
                    t.lat = c; t.rdata = t.w ? 32'h0 : rd_q[c]; t.slv = err_q[c]; t.to = 1'b0;
                    return t;
                end
                if (t.tmo != 0 && k == t.tmo) begin
                    t.lat = c; t.rdata = 32'h0; t.slv = 1'b1; t.to = 1'b1;
                    return t;
                end
            end
        end
        return t;
    endfunction

    task automatic check_fields(input txn_t t);
        check32("paddr", paddr, t.addr);
        check32("pwdata", pwdata, t.wdata);
        check1("pwrite", pwrite, t.w);
        check32("pauser", pauser, t.user);
        check32("pprot", 32'(pprot), 32'(t.prot));
    endtask

    // Starts and ends one cycle past a rising edge with the DUT idle.
    task automatic run_txn(input txn_t t);
        check1("idle_cmd_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = t.w; cmd_addr = t.addr; cmd_wdata = t.wdata;
        cmd_user = t.user; cmd_prot = t.prot; tmo_cycles = 16'(t.tmo);
        clk_en = 1'($urandom_range(0, 1)); pready = 1'($urandom_range(0, 1));
        for (int c = 0; c < t.lat; c++) begin
            @(posedge aclk); #1;
            check1("psel_held", psel, 1'b1);
            check1("penable", penable, c >= t.s);
            check1("rsp_valid_early", rsp_valid, 1'b0);
            check1("cmd_ready_busy", cmd_ready, 1'b0);
            check_fields(t);
            cmd_valid = 1'($urandom_range(0, 1)); cmd_write = 1'($urandom_range(0, 1));
            cmd_addr = $urandom; cmd_wdata = $urandom; cmd_user = $urandom;
            cmd_prot = 3'($urandom_range(0, 7)); rsp_ready = 1'($urandom_range(0, 1));
            clk_en = en_q[c+1]; pready = rdy_q[c+1]; pslverr = err_q[c+1]; prdata = rd_q[c+1];
        end
        @(posedge aclk); #1;
        check1("rsp_valid", rsp_valid, 1'b1);
        check1("psel_done", psel, 1'b0);
        check1("penable_done", penable, 1'b0);
        check32("rsp_rdata", rsp_rdata, t.rdata);
        check1("rsp_slverr", rsp_slverr, t.slv);
        check1("rsp_timeout", rsp_timeout, t.to);
        check_fields(t);
        for (int h = 0; h < t.hold; h++) begin
            rsp_ready = 1'b0; clk_en = 1'($urandom_range(0, 1)); pready = 1'($urandom_range(0, 1));
            prdata = $urandom;
            @(posedge aclk); #1;
            check1("rsp_hold_valid", rsp_valid, 1'b1);
            check32("rsp_hold_rdata", rsp_rdata, t.rdata);
            check1("rsp_hold_err", rsp_slverr, t.slv);
            check1("rsp_hold_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1; cmd_valid = 1'b1;
        @(posedge aclk); #1;
        exp_txn++;
        if (t.slv || t.to) exp_err++;
        if (t.to) exp_tmo++;
        check1("rsp_cleared", rsp_valid, 1'b0);
        check1("cmd_ready_after", cmd_ready, 1'b1);
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        @(posedge aclk); #1;
        check1("no_accept_on_rsp", busy, 1'b0);
        check_fields(t);
    endtask

    task automatic check_stats();
`ifdef CALIPTRA_FPGA_SYNC_APB_STATS_EN
        check32("stat_txn", stat_txn, 32'(exp_txn));
        check32("stat_err", 32'(stat_err), 32'(16'(exp_err)));
        check32("stat_tmo", 32'(stat_tmo), 32'(16'(exp_tmo)));
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t vec[8];
        txn_t t;

        //            w  addr          wdata         user          prot tmo hold per rdy   prd           err lat   s  rdata         slv to
        vec[0] = '{1'b0, 32'h3003_0000, 32'h0,        32'h1111_0001, 3'd0, 0, 2, 1,  1,   32'hDEAD_BEEF, 1'b0, 2,    1, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vec[1] = '{1'b1, 32'h3003_001C, 32'h1234_5678, 32'hFFFF_FFFF, 3'd2, 0, 2, 1,  6,   32'hCAFE_0000, 1'b1, 6,    1, 32'h0,         1'b1, 1'b0};
        vec[2] = '{1'b0, 32'h3003_0040, 32'h0,        32'h0000_0005, 3'd1, 0, 2, 3,  0,   32'hA5A5_0001, 1'b0, 6,    3, 32'hA5A5_0001, 1'b0, 1'b0};
        vec[3] = '{1'b0, 32'h3003_0044, 32'h0,        32'h0000_0007, 3'd3, 5, 2, 1,  -1,  32'h5555_5555, 1'b0, 6,    1, 32'h0,         1'b1, 1'b1};
        vec[4] = '{1'b0, 32'h3003_0048, 32'h0,        32'h0000_0008, 3'd4, 5, 2, 1,  6,   32'h0BAD_F00D, 1'b0, 6,    1, 32'h0BAD_F00D, 1'b0, 1'b0};
        vec[5] = '{1'b0, 32'h3003_004C, 32'h0,        32'h0000_0009, 3'd5, 1, 1, 1,  -1,  32'h0000_0001, 1'b0, 2,    1, 32'h0,         1'b1, 1'b1};
        vec[6] = '{1'b1, 32'h3003_0050, 32'h8765_4321, 32'h0000_000A, 3'd6, 3, 0, 2,  6,   32'h2222_2222, 1'b0, 6,    2, 32'h0,         1'b0, 1'b0};
        vec[7] = '{1'b0, 32'h3003_0054, 32'h0,        32'h0000_000B, 3'd7, 0, 1, 1,  1002, 32'h0000_0001, 1'b0, 1002, 1, 32'h0000_0001, 1'b0, 1'b0};

        rstn = 1'b0; clk_en = 1'b0; tmo_cycles = '0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_user = '0; cmd_prot = '0; rsp_ready = 1'b0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        @(posedge aclk); #1;
        check1("rst_cmd_ready", cmd_ready, 1'b1);
        check1("rst_busy", busy, 1'b0);
        check1("rst_psel", psel, 1'b0);
        check1("rst_penable", penable, 1'b0);
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check32("rst_paddr", paddr, 32'h0);
        check32("rst_rsp_rdata", rsp_rdata, 32'h0);
        check1("rst_rsp_timeout", rsp_timeout, 1'b0);
        check_stats();
        rstn = 1'b1;
        @(posedge aclk); #1;

        for (int i = 0; i < 8; i++) begin
            fill_periodic(vec[i]);
            run_txn(vec[i]);
            if (i == 4) begin
`ifdef CALIPTRA_FPGA_SYNC_APB_STATS_EN
                check32("stat_txn_plan", stat_txn, 32'd5);
                check32("stat_err_plan", 32'(stat_err), 32'd2);
                check32("stat_tmo_plan", 32'(stat_tmo), 32'd1);
`endif
            end
        end
        check_stats();

        // Reset asserted while the transfer sits in ACCESS with pready low.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h3003_0060;
        clk_en = 1'b1; pready = 1'b0; tmo_cycles = '0;
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        @(posedge aclk); #1;
        check1("rst_mid_in_access", penable, 1'b1);
        rstn = 1'b0;
        #1;
        check1("rst_mid_psel", psel, 1'b0);
        check1("rst_mid_penable", penable, 1'b0);
        check1("rst_mid_rsp_valid", rsp_valid, 1'b0);
        check1("rst_mid_cmd_ready", cmd_ready, 1'b1);
        exp_txn = 0; exp_err = 0; exp_tmo = 0;
        check_stats();
        @(negedge aclk);
        rstn = 1'b1; pready = 1'b1; rsp_ready = 1'b1;
        repeat (4) begin
            @(posedge aclk); #1;
            check1("rst_no_rsp", rsp_valid, 1'b0);
            check1("rst_idle", busy, 1'b0);
        end
        rsp_ready = 1'b0;
        fill_periodic(vec[0]);
        run_txn(vec[0]);

        for (int n = 0; n < NRND; n++) begin
            t.w = 1'($urandom_range(0, 1)); t.addr = $urandom; t.wdata = $urandom;
            t.user = $urandom; t.prot = 3'($urandom_range(0, 7));
            t.tmo = $urandom_range(0, 6); t.hold = $urandom_range(0, 2);
            for (int c = 0; c < MAXC; c++) begin
                en_q[c]  = ($urandom_range(0, 2) != 0) || (c >= 38);
                rdy_q[c] = ($urandom_range(0, 2) == 0) || (c >= 38);
                err_q[c] = 1'($urandom_range(0, 1));
                rd_q[c]  = $urandom;
            end
            t = predict(t);
            run_txn(t);
        end
        check_stats();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
